imem_loader: RTL and testbench
==============================

# imem_loader

Program loader for the single-cycle RISC-V computer: receives an instruction image as a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them into instruction memory. It holds the CPU in reset for the whole load and releases it only after the image is complete. It is the write side of the instruction ROM that the CPU fetches from.

## Interface

- `ADDR_WIDTH`, 7, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; honoured in IDLE, DONE and ERR only.
- `rx_valid`  in  1  byte-stream valid.
- `rx_data`  in  8  byte-stream data.
- `rx_ready`  out  1  byte-stream ready.
- `im_we`  out  1  instruction-memory write enable, one-cycle pulse per word.
- `im_addr`  out  ADDR_WIDTH  word address for the write.
- `im_wdata`  out  32  word for the write.
- `cpu_rstn`  out  1  active-low reset to the CPU.
- `busy`  out  1  high in LEN0, LEN1, DATA and CSUM.
- `done`  out  1  high in DONE.
- `err`  out  1  high in ERR.

## Operation

- **Frame format:** LEN_LO, LEN_HI (16-bit word count N), then 4·N payload bytes, then one checksum byte if `IMEM_LOADER_CHECKSUM_EN` is defined.
- **Byte transfer:** a byte is accepted on a rising edge where `rx_valid && rx_ready`. `rx_ready` = 1 exactly in LEN0, LEN1, DATA and CSUM. `rx_data` is ignored otherwise.
- **State machine:**
  - IDLE → LEN0 on `start`.
  - LEN0 → LEN1 on accepting a byte.
  - LEN1, on accepting a byte:
    - N > 2^ADDR_WIDTH → ERR.
    - N = 0 → CSUM, or DONE without the macro.
    - else → DATA.
  - DATA: a 2-bit byte counter places byte k at bits [8k+7:8k]. On the 4th byte, `im_wdata` ← assembled word, `im_addr` ← word index, and `im_we` = 1 for the next cycle. The word index starts at 0 and increments after each write. After word N−1, go to CSUM, or DONE without the macro.
  - DONE / ERR → LEN0 on `start`. Word index, byte counter and checksum are cleared.
- **Ignored `start`:** `start` in LEN0/LEN1/DATA/CSUM is ignored.
- **`cpu_rstn`:** registered from (state == DONE), so it is 0 in every other state.
- **Restart from DONE:** the CPU is re-reset on the cycle after `start`.
- **Wrap:** N = 2^ADDR_WIDTH is legal. The last write goes to address 2^ADDR_WIDTH−1, and the word index never wraps onto address 0.
- **Arithmetic widths:** length register 16 bits, word index ADDR_WIDTH+1 bits, N compared unsigned.

## Timing

- **Reset values (async on `rst`):** state IDLE, `rx_ready` 0, `im_we` 0, `im_addr` 0, `im_wdata` 0, `cpu_rstn` 0, `busy` 0, `done` 0, `err` 0, all counters 0.
- **Write latency:** 4th byte accepted at edge E → `im_we`, `im_addr`, `im_wdata` valid for the cycle E..E+1. The memory commits at E+1.
- **Completion:** last data byte accepted at edge E → `done` = 1 from E. `cpu_rstn` = 1 from E+1, after the last write has committed.
- **Back-pressure:** none. `rx_ready` stays high through DATA, including `im_we` cycles. Gaps in `rx_valid` stall the FSM with no effect on data.
- **Reset mid-load:** `rst` asserted at any point returns to IDLE immediately, drops `im_we`, and keeps `cpu_rstn` low. Words already written remain in memory, and no further writes are issued.
- **`start` timing:** `start` in the same cycle as `rst` is ignored. `start` asserted for several cycles in IDLE acts as one request.

## Configuration

- **`IMEM_LOADER_CHECKSUM_EN` defined:**
  - CSUM state expects one byte equal to the XOR of all 4·N payload bytes; the checksum is 0 when N = 0.
  - Match → DONE. Mismatch → ERR, and `cpu_rstn` stays 0.
  - Transition happens on the edge accepting the checksum byte.
  - The final `im_we` pulse occurs during the first CSUM cycle.
- **Not defined:** no CSUM state, no checksum register. The FSM goes DATA → DONE directly.

## Test plan

- **Reset:** assert `rst` mid-cycle with `clk` stopped → immediately `rx_ready` = 0, `im_we` = 0, `cpu_rstn` = 0, `done` = 0, `err` = 0.
- **Two-word load:** `start`, then bytes 02 00 13 05 00 00 93 05 15 00 back-to-back.
  - Writes addr 0 = 0x00000513 and addr 1 = 0x00150593, one `im_we` pulse each.
  - `done` = 1 the cycle after the last byte; `cpu_rstn` = 1 one cycle later.
  - Repeat with random `rx_valid` gaps → identical writes.
- **Empty image:** N = 0, header 00 00 → no `im_we`, `done` = 1. Without the macro this is immediate; with the macro it follows checksum byte 00.
- **Oversize image:** ADDR_WIDTH = 7, header 81 00 (N = 129) → `err` = 1 after the second byte, zero writes, `rx_ready` = 0, `cpu_rstn` = 0. A following `start` with a valid frame recovers to DONE.
- **Reset mid-load:** `rst` pulsed after 3 of 5 words are written → IDLE, no further `im_we`, `cpu_rstn` = 0. A fresh `start` plus the full 5-word frame writes addr 0–4 correctly.
- **Checksum (macro defined):** frame 01 00 AA BB CC DD, then checksum 00 → DONE. Same frame with checksum 01 → ERR with `cpu_rstn` held 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed byte image into instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_rstn,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM = 3'd4,
`endif
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

  state_t                state;
  state_t                next;
  logic [7:0]            len_lo;
  logic [15:0]           len;
  logic [ADDR_WIDTH:0]   widx;
  logic [ADDR_WIDTH:0]   widx_nx;
  logic [1:0]            bcnt;
  logic [23:0]           wbuf;
  logic [15:0]           n_full;
  logic                  accept;
  logic                  go;
  logic                  too_big;
  logic                  last_word;
  logic                  word_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign accept  = rx_valid && rx_ready;
  assign n_full  = {rx_data, len_lo};
  assign too_big = {1'b0, n_full} > CAP;
  assign widx_nx = widx + 1'b1;

  // word index is one bit wider than the address so N = 2^ADDR_WIDTH ends cleanly
  assign last_word =
    {{(16-ADDR_WIDTH){1'b0}}, widx_nx} == {1'b0, len};

  assign word_done = accept && (state == S_DATA) && (bcnt == 2'd3);

  assign go = start &&
    ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE: begin
        if (start) next = S_LEN0;
      end
      S_LEN0: begin
        if (accept) next = S_LEN1;
      end
      S_LEN1: begin
        if (accept) begin
          if (too_big) begin
            next = S_ERR;
          end else if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            next = S_CSUM;
`else
            next = S_DONE;
`endif
          end else begin
            next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_done && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next = S_CSUM;
`else
          next = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) next = (rx_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        if (start) next = S_LEN0;
      end
      S_ERR: begin
        if (start) next = S_LEN0;
      end
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_LEN0) || (state == S_LEN1) ||
           (state == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    busy = busy || (state == S_CSUM);
`endif
    rx_ready = busy;
    done     = (state == S_DONE);
    err      = (state == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      cpu_rstn <= 1'b0;
      len_lo   <= '0;
      len      <= '0;
      widx     <= '0;
      bcnt     <= '0;
      wbuf     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      im_we    <= 1'b0;
      cpu_rstn <= (state == S_DONE);
      if (go) begin
        widx <= '0;
        bcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end
      if (accept && state == S_LEN0) len_lo <= rx_data;
      if (accept && state == S_LEN1) len <= n_full;
      if (accept && state == S_DATA) begin
        bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ rx_data;
`endif
        unique case (bcnt)
          2'd0: wbuf[7:0]   <= rx_data;
          2'd1: wbuf[15:8]  <= rx_data;
          2'd2: wbuf[23:16] <= rx_data;
          default: begin
            im_we    <= 1'b1;
            im_addr  <= widx[ADDR_WIDTH-1:0];
            im_wdata <= {rx_data, wbuf};
            widx     <= widx_nx;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes.
// Follows IMEM_LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_loader;

  localparam int AW = 7;

  logic          clk;
  logic          rst;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rstn;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rstn (cpu_rstn),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int            n_chk;
  int            n_pass;
  int            wr_cnt;
  logic [38:0]   exp_q[$];
  logic [31:0]   img[0:255];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    logic [38:0] e;
    if (im_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("we_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(im_addr), 64'(e[38:32]));
        check("wr_data", 64'(im_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int cyc);
    start = 1'b1;
    repeat (cyc) tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("rdy_timeout", 64'd0, 64'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  // lim < 0 sends the whole frame; otherwise stops after lim payload bytes
  task automatic send_frame(input int n, input bit gaps, input int lim);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    logic [15:0] hdr;
    int          sent;
    x    = 8'h00;
    sent = 0;
    hdr  = 16'(n);
    send_byte(hdr[7:0], gaps);
    send_byte(hdr[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        if (lim >= 0 && sent >= lim) break;
        b = w[8*k +: 8];
        x = x ^ b;
        if (k == 3) exp_q.push_back({7'(i), w});
        send_byte(b, gaps);
        sent++;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (lim < 0) send_byte(x, gaps);
`endif
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_rstn_lag"}, 64'(cpu_rstn), 64'd0);
    tick();
    check({tag, "_rstn"}, 64'(cpu_rstn), 64'd1);
  endtask

  initial begin
    int w0;
    n_chk    = 0;
    n_pass   = 0;
    wr_cnt   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    #2 rst = 1'b1;
    #1;
    check("rst_ready", 64'(rx_ready), 64'd0);
    check("rst_we", 64'(im_we), 64'd0);
    check("rst_rstn", 64'(cpu_rstn), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr", 64'(im_addr), 64'd0);
    check("rst_wdata", 64'(im_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    img[0] = 32'h00000513;
    img[1] = 32'h00150593;
    pulse_start(1);
    check("t2_busy", 64'(busy), 64'd1);
    w0 = wr_cnt;
    send_frame(2, 1'b0, -1);
    check_done("t2");
    check("t2_wr", 64'(wr_cnt - w0), 64'd2);

    pulse_start(1);
    tick();
    check("rerst_rstn", 64'(cpu_rstn), 64'd0);
    check("rerst_done", 64'(done), 64'd0);
    w0 = wr_cnt;
    send_frame(2, 1'b1, -1);
    check_done("t3");
    check("t3_wr", 64'(wr_cnt - w0), 64'd2);

    pulse_start(1);
    w0 = wr_cnt;
    send_frame(0, 1'b0, -1);
    check_done("empty");
    check("empty_wr", 64'(wr_cnt - w0), 64'd0);

    pulse_start(1);
    w0 = wr_cnt;
    send_byte(8'h81, 1'b0);
    send_byte(8'h00, 1'b0);
    check("big_err", 64'(err), 64'd1);
    check("big_ready", 64'(rx_ready), 64'd0);
    check("big_busy", 64'(busy), 64'd0);
    tick();
    check("big_rstn", 64'(cpu_rstn), 64'd0);
    check("big_wr", 64'(wr_cnt - w0), 64'd0);
    pulse_start(1);
    send_frame(2, 1'b0, -1);
    check_done("recover");

    for (int i = 0; i < 128; i++) img[i] = $urandom;
    pulse_start(1);
    w0 = wr_cnt;
    send_frame(128, 1'b1, -1);
    check_done("wrap");
    check("wrap_wr", 64'(wr_cnt - w0), 64'd128);

    for (int i = 0; i < 5; i++) img[i] = $urandom;
    pulse_start(1);
    w0 = wr_cnt;
    send_frame(5, 1'b0, 12);
    tick();
    rst   = 1'b1;
    start = 1'b1;
    #1;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_we", 64'(im_we), 64'd0);
    check("mid_rstn", 64'(cpu_rstn), 64'd0);
    tick();
    start = 1'b0;
    rst   = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hff;
    repeat (3) tick();
    rx_valid = 1'b0;
    check("mid_idle", 64'(busy), 64'd0);
    check("mid_wr", 64'(wr_cnt - w0), 64'd3);
    pulse_start(3);
    send_frame(5, 1'b0, -1);
    check_done("reload");
    check("reload_wr", 64'(wr_cnt - w0), 64'd8);

    img[0] = 32'hddccbbaa;
    pulse_start(1);
    send_frame(1, 1'b0, -1);
    check_done("csum_ok");
`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start(1);
    send_frame(1, 1'b0, 4);
    send_byte(8'h01, 1'b0);
    check("csum_err", 64'(err), 64'd1);
    check("csum_done", 64'(done), 64'd0);
    tick();
    check("csum_rstn", 64'(cpu_rstn), 64'd0);
`endif

    repeat (3) tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
